// File: rtl/shift_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shift_seq_pkg
// Purpose  : Shared types and default sizing for the shift-chain sequencer.
// Contents : state_t   - sequencer state (IDLE / SHIFT)
//            DEFAULT_DEPTH, DEFAULT_WIDTH - default chain geometry
// Revision : 1.0 - initial release
// ============================================================================
package shift_seq_pkg;

  localparam int DEFAULT_DEPTH = 4;
  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/shift_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : shift_seq_ctrl_if
// Purpose  : Bundles the vector input port, the word output stream and the
//            abort/busy side-band of the shift-chain sequencer.
// Modports : master - producer/consumer side (drives in_valid, in_data,
//                     out_ready, abort)
//            slave  - sequencer side (drives in_ready, out_valid, out_data,
//                     out_last, busy)
// Revision : 1.0 - initial release
// ============================================================================
interface shift_seq_ctrl_if
  import shift_seq_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic                   in_valid;
  logic                   in_ready;
  logic [DEPTH*WIDTH-1:0] in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       out_data;
  logic                   out_last;
  logic                   abort;
  logic                   busy;

  modport master (
    output in_valid, in_data, out_ready, abort,
    input  in_ready, out_valid, out_data, out_last, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready, abort,
    output in_ready, out_valid, out_data, out_last, busy
  );

endinterface
`default_nettype wire

// File: rtl/shift_seq_ctrl_stage.sv
`default_nettype none
// ============================================================================
// Module   : shift_stage
// Purpose  : One WIDTH-bit stage of the shift chain. Load has priority over
//            shift; with neither asserted the stage holds.
// Ports    : clk       - clock
//            reset     - asynchronous active-low clear
//            load      - capture load_data
//            shift     - capture shift_in (from the next stage up)
//            load_data - parallel load value
//            shift_in  - serial value from the neighbouring stage
//            q         - stage contents
// Revision : 1.0 - initial release
// ============================================================================
module shift_stage #(
  parameter int WIDTH = 8
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             load,
  input  wire logic             shift,
  input  wire logic [WIDTH-1:0] load_data,
  input  wire logic [WIDTH-1:0] shift_in,
  output logic      [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= load_data;
    end else if (shift) begin
      r_q <= shift_in;
    end
  end

  assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/shift_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : shift_seq_ctrl
// Purpose  : Accepts one DEPTH-word vector, parallel-loads it into a chain of
//            shift stages and streams it out word 0 first, flagging the last
//            word. A new vector may be accepted on the last beat for
//            gap-free back-to-back streaming. abort discards the vector in
//            flight.
// Ports    : clk   - clock
//            reset - asynchronous active-low reset
//            bus   - shift_seq_ctrl_if.slave (vector in, word stream out,
//                    abort, busy)
// Revision : 1.0 - initial release
// ============================================================================
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input wire logic       clk,
  input wire logic       reset,
  shift_seq_ctrl_if.slave bus
);

  localparam int              C_CW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [C_CW-1:0] C_LAST = C_CW'(DEPTH - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [C_CW-1:0] r_cnt;
  logic [C_CW-1:0] w_cnt_nxt;

  logic [WIDTH-1:0] w_stage_q  [DEPTH];
  logic [WIDTH-1:0] w_load_data[DEPTH];
  logic [WIDTH-1:0] w_shift_in [DEPTH];

  logic w_in_shift;
  logic w_last;
  logic w_beat;
  logic w_in_ready;
  logic w_load;
  logic w_clear;

  // A beat is only accepted when abort is low: abort discards the word even
  // if the consumer signalled ready in the same cycle.
  assign w_in_shift = (r_state == SHIFT);
  assign w_last     = w_in_shift && (r_cnt == C_LAST);
  assign w_beat     = w_in_shift && bus.out_ready && !bus.abort;
  assign w_in_ready = !w_in_shift || (w_last && w_beat);
  assign w_load     = bus.in_valid && w_in_ready;
  // Abort in SHIFT wipes the chain by loading zeros into every stage.
  assign w_clear    = w_in_shift && bus.abort;

  // --------------------------------------------------------------------------
  // Shift chain
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    assign w_load_data[k] = w_load ? bus.in_data[k*WIDTH +: WIDTH] : '0;

    if (k == DEPTH - 1) begin : g_tail
      assign w_shift_in[k] = '0;
    end else begin : g_body
      assign w_shift_in[k] = w_stage_q[k+1];
    end

    shift_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk      (clk),
      .reset    (reset),
      .load     (w_load || w_clear),
      .shift    (w_beat),
      .load_data(w_load_data[k]),
      .shift_in (w_shift_in[k]),
      .q        (w_stage_q[k])
    );
  end

  // --------------------------------------------------------------------------
  // State / beat-counter register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        // abort is ignored here; an offered vector is always taken.
        if (w_load) begin
          w_state_nxt = SHIFT;
          w_cnt_nxt   = '0;
        end
      end
      SHIFT: begin
        if (bus.abort) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (w_beat) begin
          if (w_last) begin
            // Stay in SHIFT when the next vector is taken on this beat.
            w_state_nxt = w_load ? SHIFT : IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + C_CW'(1);
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output decode
  // --------------------------------------------------------------------------
  logic             w_out_valid;
  logic             w_out_last;
  logic             w_busy;
  logic [WIDTH-1:0] w_out_data;

  always_comb begin
    w_out_valid = w_in_shift;
    w_out_last  = w_last;
    w_busy      = (r_state != IDLE);
    w_out_data  = w_stage_q[0];
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_last  = w_out_last;
  assign bus.busy      = w_busy;
  assign bus.out_data  = w_out_data;

endmodule
`default_nettype wire

// File: doc/shift_seq_ctrl.md
# shift_seq_ctrl

Sequencer for a chain of DEPTH byte-wide shift stages. Accepts one parallel vector of DEPTH words on a valid/ready input port, parallel-loads it into the chain, then shifts it out one word per accepted beat on a valid/ready output stream, flagging the last word. Sits between a vector producer, such as a layer buffer, and a word-serial consumer; it owns the chain's load/shift controls so no other block drives them.

## Interface
Parameters:
- DEPTH, 4, number of stages and words per vector (≥2)
- WIDTH, 8, bits per word/stage

Ports:
- clk  in  1  single clock; all state updates on posedge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  producer has a vector
- in_ready  out  1  block accepts a vector this cycle
- in_data  in  DEPTH*WIDTH  vector; word k = bits [k*WIDTH +: WIDTH], word 0 sent first
- out_valid  out  1  out_data holds a valid word
- out_ready  in  1  consumer accepts the word this cycle
- out_data  out  WIDTH  current word (stage 0)
- out_last  out  1  current word is word DEPTH-1 of the vector
- abort  in  1  discard the vector in flight
- busy  out  1  high whenever state ≠ IDLE

## Operation
- States: IDLE, SHIFT. Beat counter cnt, width $clog2(DEPTH), range 0..DEPTH-1.
- In reset (reset=0): state=IDLE, cnt=0, all stages=0. Outputs: in_ready=1 after reset is released, out_valid=0, out_data=0, out_last=0, busy=0.
- IDLE: in_ready=1, out_valid=0. When in_valid&&in_ready: stage[k]<=word k, cnt<=0, state<=SHIFT.
- SHIFT: out_valid=1, out_data=stage[0], out_last=(cnt==DEPTH-1).
  - On out_valid&&out_ready: stage[i]<=stage[i+1], stage[DEPTH-1]<=0, cnt<=cnt+1.
  - With no out_ready: all stages and cnt hold. out_data is stable while stalled.
- Last beat (cnt==DEPTH-1 accepted):
  - With no new vector: state<=IDLE, cnt<=0.
  - With a new vector: in_ready=1 combinationally in that cycle (SHIFT && out_last && out_ready && !abort). When in_valid is also high, the chain loads the new vector, cnt<=0, and the state stays SHIFT. This gives zero-bubble back-to-back vectors.
- in_ready=0 in SHIFT except in the last-beat case above.
- abort, sampled each cycle:
  - In SHIFT: next state IDLE, cnt<=0, stages cleared to 0, and no word is considered accepted even if out_ready=1.
  - abort has priority over a simultaneous last-beat load: in_ready=0 that cycle.
  - In IDLE, abort is ignored; a vector offered together with abort is still accepted.
- Arithmetic: cnt increments only on an accepted beat and never exceeds DEPTH-1; no wrap past DEPTH-1 is reachable.

## Timing
- Input-to-output latency: a vector accepted at edge t makes word 0 visible on out_data with out_valid=1 from edge t (registered) onward, i.e. in the cycle after the handshake.
- Throughput: one word per cycle with out_ready held high, so a vector takes DEPTH cycles and back-to-back vectors have no idle cycle.
- in_ready depends combinationally on out_ready and abort. All other outputs are registered or decoded from registered state only.
- Reset assertion at any time, mid-vector included, clears state asynchronously. The first vector can be accepted at the first posedge after deassertion.

## Structure
- Package shift_seq_pkg: state typedef enum logic {IDLE, SHIFT}, default DEPTH/WIDTH localparams.
- Sub-module shift_stage: one WIDTH-bit register with async active-low clear and three modes (load, shift-in, hold). It is instantiated DEPTH times in a generate loop. The FSM, counter and handshake logic stay in shift_seq_ctrl.

## Test plan
- Single vector, DEPTH=4, in_data=0x44332211, out_ready=1 → out_data 11,22,33,44 on four consecutive cycles; out_last only on 44; busy falls the following cycle.
- Back-to-back: second vector 0xDDCCBBAA held valid during the first → in_ready=1 only on the 44 beat; stream 11,22,33,44,AA,BB,CC,DD with no gap.
- Backpressure: out_ready low for 3 cycles after word 22 → out_data stays 22, cnt holds; stream resumes 33,44 with no loss or duplication.
- Abort on word 33 with out_ready=1 → next cycle IDLE, out_valid=0, in_ready=1; the next vector starts at its word 0.
- Abort together with a last-beat load offer → in_ready=0, that vector is not consumed; it is accepted next cycle from IDLE.
- reset driven low mid-vector (after word 22) → out_valid, out_last and busy drop immediately; after release, a new vector streams correctly from word 0.
